// File: rtl/trivium_sched_if.sv
// Bundle of the serial load, requester and core-control signals of trivium_sched.
// master = environment (loader, requesters, Trivium core); slave = the scheduler.
interface trivium_sched_if #(
   parameter int N_REQ   = 2,
   parameter int LIMIT_W = 16
);
   logic               ld_bit;
   logic               ld_vld;
   logic               ld_rdy;
   logic               rekey;
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   gnt;
   logic               ks_bit;
   logic               ks_vld;
   logic               ready;
   logic               rekey_req;
   logic [LIMIT_W-1:0] ks_cnt;
   logic [79:0]        core_key;
   logic [79:0]        core_iv;
   logic               core_load;
   logic               core_step;
   logic               core_z;

   modport master (
      output ld_bit, ld_vld, rekey, req, core_z,
      input  ld_rdy, gnt, ks_bit, ks_vld, ready, rekey_req, ks_cnt,
             core_key, core_iv, core_load, core_step
   );

   modport slave (
      input  ld_bit, ld_vld, rekey, req, core_z,
      output ld_rdy, gnt, ks_bit, ks_vld, ready, rekey_req, ks_cnt,
             core_key, core_iv, core_load, core_step
   );
endinterface

// File: rtl/trivium_sched.sv
// Trivium keystream scheduler: serial key/IV load, core warm-up, per-bit arbitration, rekey on limit.
// Build option TRIV_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module trivium_sched #(
   parameter int N_REQ       = 2,
   parameter int INIT_ROUNDS = 1152,
   parameter int LIMIT_W     = 16
) (
   input logic             clk,
   input logic             rst,
   trivium_sched_if.slave  bus
);
   localparam int                 PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [10:0]        WARM_LAST = 11'(INIT_ROUNDS - 1);
   localparam logic [LIMIT_W-1:0] KS_LAST   = {{(LIMIT_W-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      S_LOAD    = 3'd0,
      S_PRIME   = 3'd1,
      S_WARM    = 3'd2,
      S_RUN     = 3'd3,
      S_EXHAUST = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         ld_cnt_q, ld_cnt_d;
   logic [10:0]        warm_cnt_q, warm_cnt_d;
   logic [LIMIT_W-1:0] ks_cnt_q, ks_cnt_d;
   logic [79:0]        key_q, key_d;
   logic [79:0]        iv_q, iv_d;

   logic               found_s;
   logic [PTR_W-1:0]   win_s;
   logic [N_REQ-1:0]   gnt_s;
   logic               ks_vld_s, ks_bit_s, core_step_s, core_load_s;
   logic               ld_rdy_s, ready_s, rekey_req_s;

`ifndef TRIV_FIXED_PRIO_EN
   logic [PTR_W-1:0]   rr_q, rr_d;

   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      s = (s >= N_REQ) ? s - N_REQ : s;
      return PTR_W'(s);
   endfunction
`endif

   // Winner search: loop runs downward so the smallest offset is the last, winning assignment
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef TRIV_FIXED_PRIO_EN
         if (bus.req[PTR_W'(i)]) begin
            found_s = 1'b1;
            win_s   = PTR_W'(i);
         end else begin
            found_s = found_s;
         end
`else
         if (bus.req[wrap_idx(rr_q, i)]) begin
            found_s = 1'b1;
            win_s   = wrap_idx(rr_q, i);
         end else begin
            found_s = found_s;
         end
`endif
      end
   end

   // Next-state and output decode from the registered state
   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      warm_cnt_d  = warm_cnt_q;
      ks_cnt_d    = ks_cnt_q;
      key_d       = key_q;
      iv_d        = iv_q;
      gnt_s       = '0;
      ks_vld_s    = 1'b0;
      ks_bit_s    = 1'b0;
      core_step_s = 1'b0;
      core_load_s = 1'b0;
      ld_rdy_s    = 1'b0;
      ready_s     = 1'b0;
      rekey_req_s = 1'b0;
      case (state_q)
         S_LOAD: begin
            ld_rdy_s = 1'b1;
            if (bus.ld_vld) begin
               // key and IV form one 160-bit right-shift chain, so bit 0 lands in key[0]
               iv_d  = {bus.ld_bit, iv_q[79:1]};
               key_d = {iv_q[0], key_q[79:1]};
               if (ld_cnt_q == 8'd159) begin
                  ld_cnt_d = 8'd0;
                  state_d  = S_PRIME;
               end else begin
                  ld_cnt_d = ld_cnt_q + 8'd1;
               end
            end else begin
               ld_cnt_d = ld_cnt_q;
            end
         end
         S_PRIME: begin
            core_load_s = 1'b1;
            warm_cnt_d  = 11'd0;
            state_d     = S_WARM;
         end
         S_WARM: begin
            core_step_s = 1'b1;
            if (warm_cnt_q == WARM_LAST) begin
               warm_cnt_d = 11'd0;
               state_d    = S_RUN;
            end else begin
               warm_cnt_d = warm_cnt_q + 11'd1;
            end
         end
         S_RUN: begin
            ready_s = 1'b1;
            if (found_s) begin
               gnt_s[win_s] = 1'b1;
               ks_vld_s     = 1'b1;
               ks_bit_s     = bus.core_z;
               core_step_s  = 1'b1;
               ks_cnt_d     = ks_cnt_q + {{(LIMIT_W-1){1'b0}}, 1'b1};
               state_d      = (ks_cnt_q == KS_LAST) ? S_EXHAUST : S_RUN;
            end else begin
               ks_cnt_d = ks_cnt_q;
            end
         end
         S_EXHAUST: begin
            rekey_req_s = 1'b1;
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
      // Rekey overrides everything, including a bit or grant decided above
      if (bus.rekey) begin
         state_d     = S_LOAD;
         ld_cnt_d    = 8'd0;
         warm_cnt_d  = 11'd0;
         ks_cnt_d    = '0;
         key_d       = key_q;
         iv_d        = iv_q;
         gnt_s       = '0;
         ks_vld_s    = 1'b0;
         ks_bit_s    = 1'b0;
         core_step_s = 1'b0;
      end else begin
         state_d = state_d;
      end
   end

   // State, counters and key/IV registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LOAD;
         ld_cnt_q   <= 8'd0;
         warm_cnt_q <= 11'd0;
         ks_cnt_q   <= '0;
         key_q      <= 80'd0;
         iv_q       <= 80'd0;
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         warm_cnt_q <= warm_cnt_d;
         ks_cnt_q   <= ks_cnt_d;
         key_q      <= key_d;
         iv_q       <= iv_d;
      end
   end

`ifndef TRIV_FIXED_PRIO_EN
   // Pointer moves past the winner only when a bit is really issued; survives rekey
   always_comb begin
      if (ks_vld_s) begin
         rr_d = (win_s == PTR_W'(N_REQ - 1)) ? '0 : win_s + PTR_W'(1);
      end else begin
         rr_d = rr_q;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   assign bus.ld_rdy    = ld_rdy_s;
   assign bus.gnt       = gnt_s;
   assign bus.ks_bit    = ks_bit_s;
   assign bus.ks_vld    = ks_vld_s;
   assign bus.ready     = ready_s;
   assign bus.rekey_req = rekey_req_s;
   assign bus.ks_cnt    = ks_cnt_q;
   assign bus.core_key  = key_q;
   assign bus.core_iv   = iv_q;
   assign bus.core_load = core_load_s;
   assign bus.core_step = core_step_s;
endmodule
